// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Sits in front of a registered ALU and gives it a valid/ready interface.
//   One operation is in flight at a time. The sequencer issues the operands,
//   holds them for the ALU's one-cycle latency, captures R/FLAG, and hands
//   the result to the consumer with back-pressure.
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   CMD_VALID/READY, CMD_A/B/SEL command port
//   A, B, SEL                    operand/opcode drive to the ALU
//   ALU_R, ALU_FLAG              registered ALU result and zero flag
//   RES_VALID/READY, RES_*       result port (held stable until taken)
//   OP_COUNT                     results handed off since reset (wraps)
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  input  logic [2:0]       CMD_SEL,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       SEL,
  input  logic [WIDTH-1:0] ALU_R,
  input  logic             ALU_FLAG,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_R,
  output logic             RES_FLAG,
  output logic [2:0]       RES_SEL,
  output logic             RES_ILLEGAL,
  output logic             RES_MISMATCH,
  output logic [CNT_W-1:0] OP_COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   res_r_q, res_r_d;
  logic               res_flag_q, res_flag_d;
  logic [2:0]         res_sel_q, res_sel_d;
  logic               res_ill_q, res_ill_d;
  logic               res_mis_q, res_mis_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic               cmd_ready;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    res_r_d    = res_r_q;
    res_flag_d = res_flag_q;
    res_sel_d  = res_sel_q;
    res_ill_d  = res_ill_q;
    res_mis_d  = res_mis_q;
    op_count_d = op_count_q;
    cmd_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (CMD_VALID) begin
          a_d     = CMD_A;
          b_d     = CMD_B;
          sel_d   = CMD_SEL;
          state_d = S_EXEC;
        end
      end
      // ALU samples A/B/SEL at the edge leaving this state.
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        res_r_d    = ALU_R;
        res_flag_d = ALU_FLAG;
        res_sel_d  = sel_q;
        res_ill_d  = (sel_q[2:1] == 2'b11);
        res_mis_d  = (ALU_FLAG != (ALU_R == '0));
        state_d    = S_DONE;
      end
      S_DONE: begin
        // Ready follows RES_READY combinationally so a new command can be
        // taken in the same cycle the result leaves: one op per 3 cycles.
        if (RES_READY) begin
          cmd_ready  = 1'b1;
          op_count_d = op_count_q + CNT_W'(1);
          if (CMD_VALID) begin
            a_d     = CMD_A;
            b_d     = CMD_B;
            sel_d   = CMD_SEL;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      res_r_q    <= '0;
      res_flag_q <= 1'b0;
      res_sel_q  <= '0;
      res_ill_q  <= 1'b0;
      res_mis_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      res_r_q    <= res_r_d;
      res_flag_q <= res_flag_d;
      res_sel_q  <= res_sel_d;
      res_ill_q  <= res_ill_d;
      res_mis_q  <= res_mis_d;
      op_count_q <= op_count_d;
    end
  end

  assign CMD_READY    = cmd_ready;
  assign A            = a_q;
  assign B            = b_q;
  assign SEL          = sel_q;
  assign RES_VALID    = (state_q == S_DONE);
  assign RES_R        = res_r_q;
  assign RES_FLAG     = res_flag_q;
  assign RES_SEL      = res_sel_q;
  assign RES_ILLEGAL  = res_ill_q;
  assign RES_MISMATCH = res_mis_q;
  assign OP_COUNT     = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: registered ALU model, result scoreboard,
// one task per scenario. A second instance with a 4-bit counter shares
// all inputs so counter wrap is reachable in a short run.
module tb_alu_op_sequencer;

  logic        clk = 0;
  logic        rst = 1;
  logic        cmd_valid = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0;
  logic [2:0]  cmd_sel = 0;
  logic        res_ready = 1;
  logic        force_bad = 0;

  logic        cmd_ready, res_valid, res_flag, res_ill, res_mis;
  logic [31:0] a_o, b_o, res_r, alu_r;
  logic [2:0]  sel_o, res_sel;
  logic        alu_flag;
  logic [15:0] op_count;

  logic        s_cmd_ready, s_res_valid, s_res_flag, s_res_ill, s_res_mis;
  logic [31:0] s_a, s_b, s_res_r;
  logic [2:0]  s_sel, s_res_sel;
  logic [3:0]  op_count_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] r;
    logic        f;
    logic [2:0]  sel;
    logic        ill;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          hs_q[$];
  logic [15:0] exp_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_op_sequencer #(.WIDTH(32), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_SEL(cmd_sel),
    .A(a_o), .B(b_o), .SEL(sel_o), .ALU_R(alu_r), .ALU_FLAG(alu_flag),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_R(res_r),
    .RES_FLAG(res_flag), .RES_SEL(res_sel), .RES_ILLEGAL(res_ill),
    .RES_MISMATCH(res_mis), .OP_COUNT(op_count)
  );

  alu_op_sequencer #(.WIDTH(32), .CNT_W(4)) dut_s (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(s_cmd_ready),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_SEL(cmd_sel),
    .A(s_a), .B(s_b), .SEL(s_sel), .ALU_R(alu_r), .ALU_FLAG(alu_flag),
    .RES_VALID(s_res_valid), .RES_READY(res_ready), .RES_R(s_res_r),
    .RES_FLAG(s_res_flag), .RES_SEL(s_res_sel), .RES_ILLEGAL(s_res_ill),
    .RES_MISMATCH(s_res_mis), .OP_COUNT(op_count_s)
  );

  // Registered ALU model; force_bad makes it return R=0, FLAG=0.
  always @(posedge clk) begin
    logic [31:0] r;
    case (sel_o)
      3'b000:  r = a_o & b_o;
      3'b001:  r = a_o | b_o;
      3'b010:  r = a_o + b_o;
      3'b011:  r = a_o - b_o;
      3'b100:  r = a_o * b_o;
      3'b101:  r = {31'd0, a_o < b_o};
      default: r = 32'd0;
    endcase
    if (force_bad) begin
      alu_r    <= 32'd0;
      alu_flag <= 1'b0;
    end else begin
      alu_r    <= r;
      alu_flag <= (r == 32'd0);
    end
  end

  // Result monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_cnt = 0;
    end else if (res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got r=%h sel=%b, expected no result", res_r, res_sel);
      end else begin
        e = sb.pop_front();
        if ({res_r, res_flag, res_sel, res_ill, res_mis} !== {e.r, e.f, e.sel, e.ill, e.mis}) begin
          errors++;
          $display("FAIL result: got r=%h f=%b sel=%b ill=%b mis=%b, expected r=%h f=%b sel=%b ill=%b mis=%b",
                   res_r, res_flag, res_sel, res_ill, res_mis, e.r, e.f, e.sel, e.ill, e.mis);
        end
      end
      checks++;
      if (op_count !== exp_cnt) begin
        errors++;
        $display("FAIL op_count: got %0d, expected %0d", op_count, exp_cnt);
      end
      checks++;
      if (op_count_s !== exp_cnt[3:0]) begin
        errors++;
        $display("FAIL op_count_small: got %0d, expected %0d", op_count_s, exp_cnt[3:0]);
      end
      hs_q.push_back(cyc);
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  // Present a command, wait for acceptance, record the expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                      input logic [31:0] er, input logic ef, input logic emis);
    exp_t e;
    bit   ok = 0;
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_sel = sel;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL accept_timeout: cmd_ready got 0, expected 1 within 50 cycles");
    end else begin
      e.r = er; e.f = ef; e.sel = sel; e.ill = (sel[2:1] == 2'b11); e.mis = emis;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; cmd_valid = 0; res_ready = 1;
    repeat (2) @(posedge clk);
    #1; @(negedge clk);
    checks++;
    if ({a_o, b_o, sel_o, res_valid, res_r, res_flag, res_sel, res_ill, res_mis, op_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h sel=%b v=%b r=%h cnt=%0d, expected all 0",
               a_o, b_o, sel_o, res_valid, res_r, op_count);
    end
    rst = 0;
    @(posedge clk); #1; @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat = 0;
    send(32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1'b0);
    // Count cycles from the accept edge (inclusive) until RES_VALID is seen.
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (res_valid) begin lat = k; break; end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL add_latency: got %0d, expected 3", lat);
    end
    drain();
    checks++;
    if (op_count !== 16'd1) begin
      errors++;
      $display("FAIL add_op_count: got %0d, expected 1", op_count);
    end
  endtask

  task automatic test_sub_slt();
    send(32'd3, 32'd3, 3'b011, 32'd0, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 3'b101, 32'd0, 1'b1, 1'b0);
    send(32'd1, 32'd2, 3'b101, 32'd1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    bit ok = 0;
    res_ready = 0;
    send(32'h0001_0000, 32'h0001_0000, 3'b100, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid_timeout: res_valid got 0, expected 1");
    end
    cnt0 = op_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_r, res_flag, cmd_ready, op_count} !== {1'b1, 32'd0, 1'b1, 1'b0, cnt0}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%b r=%h f=%b rdy=%b cnt=%0d, expected v=1 r=0 f=1 rdy=0 cnt=%0d",
                 i, res_valid, res_r, res_flag, cmd_ready, op_count, cnt0);
      end
    end
    @(posedge clk); #1;
    res_ready = 1;
    drain();
    checks++;
    if (op_count !== cnt0 + 16'd1) begin
      errors++;
      $display("FAIL bp_release_count: got %0d, expected %0d", op_count, cnt0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    hs_q.delete();
    send(32'h0000_F0F0, 32'h0000_FF00, 3'b000, 32'h0000_F000, 1'b0, 1'b0);
    send(32'h0000_F0F0, 32'h0000_0F0F, 3'b001, 32'h0000_FFFF, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'd1,         3'b010, 32'd0,         1'b1, 1'b0);
    send(32'd10,        32'd3,         3'b011, 32'd7,         1'b0, 1'b0);
    drain();
    checks++;
    if (hs_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, expected 4", hs_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (hs_q[i] - hs_q[i-1] != 3) begin
          errors++;
          $display("FAIL b2b_spacing: result %0d got %0d cycles, expected 3", i, hs_q[i] - hs_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    send(32'd9, 32'd4, 3'b111, 32'd0, 1'b1, 1'b0);
    send(32'd9, 32'd4, 3'b110, 32'd0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_mismatch();
    force_bad = 1;
    send(32'd20, 32'd22, 3'b010, 32'd0, 1'b0, 1'b1);
    drain();
    force_bad = 0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    send(32'd1, 32'd1, 3'b010, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;          // now in CAPT
    rst = 1;
    @(posedge clk); #1; @(negedge clk);
    checks++;
    if ({a_o, b_o, sel_o, res_valid, res_r, res_flag, res_sel, res_ill, res_mis, op_count} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got a=%h sel=%b v=%b r=%h cnt=%0d, expected all 0",
               a_o, sel_o, res_valid, res_r, op_count);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b, expected 1", cmd_ready);
    end
    rst = 0;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_dropped: res_valid got 1, expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++)
      send(32'(i), 32'd1, 3'b010, 32'(i + 1), 1'b0, 1'b0);
    drain();
    checks++;
    if (op_count_s !== 4'd0) begin
      errors++;
      $display("FAIL wrap_small: got %0d, expected 0", op_count_s);
    end
    checks++;
    if (op_count !== 16'd16) begin
      errors++;
      $display("FAIL wrap_main: got %0d, expected 16", op_count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_mismatch();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
